pio_fifo_join: RTL and testbench
================================

Name: pio_fifo_join

Overview:
- Parametrised, first-word-fall-through (FWFT) data FIFO for the PIO datapath.
- Successor to the fixed 4×32 PIO FIFO. Adds configurable width and depth.
- Adds a join mode that doubles usable capacity by borrowing the partner direction's storage, plus explicit flush, sticky overflow/underflow flags and a programmable level watermark.
- One instance per state-machine direction (TX or RX).

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 4: unjoined capacity in words. Power of two, ≥2. Storage is 2*DEPTH words.
- LW, $clog2(2*DEPTH)+1: width of level/threshold fields (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- join  in  1  1 = capacity 2*DEPTH, 0 = capacity DEPTH.
- flush  in  1  one-cycle pulse; discards all contents.
- push  in  1  write request.
- din  in  WIDTH  write data.
- pull  in  1  read request; consumes the word on dout.
- dout  out  WIDTH  head word (FWFT).
- empty  out  1  count == 0.
- full  out  1  count == CAP.
- level  out  LW  current word count.
- thresh  in  LW  watermark compare value.
- at_thresh  out  1  level >= thresh (combinational from count).
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pull attempted while empty.
- clr_ovf  in  1  clears overflow.
- clr_unf  in  1  clears underflow.

Behaviour:
- Derived values: CAP = join_q ? 2*DEPTH : DEPTH, where join_q is the registered join.
- Internal state: rd_ptr, wr_ptr (each $clog2(2*DEPTH) bits), count (LW bits), join_q, overflow, underflow.
- Reset values: all internal state 0, so empty=1, full=0, level=0, overflow=0, underflow=0.
  - at_thresh after reset = (thresh == 0).
  - dout is don't-care while empty; the bench must not check it.
- Priority per cycle, highest first: reset > join change > flush > push/pull.
- Join change (join != join_q):
  - join_q <= join.
  - Pointers and count cleared.
  - push and pull ignored; no flag updates from them in that cycle.
  - Contents are lost.
- Flush:
  - Pointers and count cleared; push and pull ignored.
  - overflow and underflow are unaffected.
- Acceptance:
  - do_push = push & !full.
  - do_pull = pull & !empty.
  - full and empty are evaluated on the current (pre-edge) count.
  - Push when full is rejected even if a pull occurs the same cycle. The pull still completes.
  - Pull when empty is rejected even if a push occurs the same cycle. The push still completes.
- Pointer updates:
  - do_push: mem[wr_ptr] <= din; wr_ptr advances.
  - do_pull: rd_ptr advances.
  - Wrap-around: a pointer advancing from CAP-1 goes to 0, not a power-of-two modulo of storage. With join_q=0, only entries 0..DEPTH-1 are used.
- Count update:
  - +1 on do_push only.
  - −1 on do_pull only.
  - Unchanged when both or neither occur.
- Read path: dout = mem[rd_ptr], combinational.
  - Push at edge N into an empty FIFO: empty=0 and dout=din valid after edge N (zero-cycle FWFT latency).
  - Pull at edge N: the next word appears on dout after edge N.
- Sticky flags:
  - overflow <= 1 when push & full, and neither a join change nor a flush is active.
  - underflow <= 1 when pull & empty, under the same condition.
  - clr_ovf / clr_unf clear the respective flag.
  - A set event in the same cycle as a clear wins: the flag stays 1.
- Reset mid-operation: all contents discarded; outputs return to their reset values after that edge.
- No combinational path from push, pull or din to full, empty, level or dout.

Test Plan:
- DEPTH=4, WIDTH=32, join=0:
  - Push 0xA0..0xA3 → full=1, level=4.
  - 5th push 0xA4 → rejected, overflow=1, level stays 4.
  - Four pulls → dout 0xA0,0xA1,0xA2,0xA3 in order, then empty=1.
- join=1 (one idle cycle for the join change):
  - Push 8 words 0..7 → full only after the 8th, level=8.
  - Pull all → 0..7 in order.
  - Pointers wrap cleanly over 3 fill/drain cycles.
- Simultaneous push/pull:
  - Level 2, push+pull same cycle → level stays 2, head advances.
  - Full, push+pull → push rejected, overflow=1, level=3.
  - Empty, push+pull → underflow=1, level=1, dout=pushed value.
- Join change and flush:
  - Level 3, toggle join → level=0, empty=1, and a push in that cycle is ignored.
  - Flush with overflow=1 → level=0, overflow stays 1.
  - clr_ovf in the same cycle as a new overflowing push → overflow=1.
- Watermark: thresh=3, push 3 words → at_thresh rises on the edge of the 3rd push, falls after one pull.
- Reset and wrap:
  - Reset asserted at level 2 → next cycle empty=1, level=0, flags 0.
  - Subsequent push 0x55 → dout=0x55.
- Parameter sweep: repeat the first two scenarios with WIDTH=8 and DEPTH=2, and with DEPTH=16.

Source files
------------

// File: rtl/pio_fifo_join.sv
// pio_fifo_join: first-word-fall-through data FIFO for one PIO state-machine direction.
//
// The storage holds 2*DEPTH words. With join_i low, only entries 0..DEPTH-1 are used.
// With join_i high, the FIFO borrows the partner direction's half and holds 2*DEPTH words.
// Changing join_i discards the contents, and so does a flush. The overflow and underflow
// flags are sticky, and a level watermark compare is provided.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   reset_i      synchronous, active-high reset
//   join_i       1 = capacity 2*DEPTH, 0 = capacity DEPTH (registered; a change clears)
//   flush_i      one-cycle pulse that discards all contents
//   push_i       write request; din_i is stored when not full
//   din_i        write data
//   pull_i       read request; consumes the word on dout_o when not empty
//   dout_o       head word, valid while empty_o is low
//   empty_o      no words held
//   full_o       word count equals the current capacity
//   level_o      current word count
//   thresh_i     watermark compare value
//   at_thresh_o  level_o >= thresh_i
//   overflow_o   sticky: push attempted while full
//   underflow_o  sticky: pull attempted while empty
//   clr_ovf_i    clears overflow_o (a same-cycle overflow event wins)
//   clr_unf_i    clears underflow_o (a same-cycle underflow event wins)

module pio_fifo_join #(
    parameter int unsigned WIDTH = 32,
    // Power of two, at least 2.
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW = $clog2(2 * DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             join_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pull_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LW-1:0]    level_o,
    input  logic [LW-1:0]    thresh_i,
    output logic             at_thresh_o,
    output logic             overflow_o,
    output logic             underflow_o,
    input  logic             clr_ovf_i,
    input  logic             clr_unf_i
);

    localparam int unsigned SLOTS = 2 * DEPTH;
    localparam int unsigned PW    = $clog2(SLOTS);

    logic [WIDTH-1:0] mem_q [SLOTS];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          join_q, join_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic [LW-1:0] cap;
    logic [PW-1:0] last_idx;
    logic          is_full, is_empty;
    logic          join_chg, quiet;
    logic          do_push, do_pull;

    // Pointers wrap at the current capacity rather than at the storage size, so an
    // unjoined FIFO never touches the partner half.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr,
                                              input logic [PW-1:0] last);
        return (ptr == last) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        cap      = join_q ? LW'(SLOTS) : LW'(DEPTH);
        last_idx = join_q ? PW'(SLOTS - 1) : PW'(DEPTH - 1);
        is_full  = (count_q == cap);
        is_empty = (count_q == '0);
        join_chg = (join_i != join_q);
        // Push/pull only take effect when neither a join change nor a flush is pending.
        quiet    = ~join_chg & ~flush_i;
        do_push  = quiet & push_i & ~is_full;
        do_pull  = quiet & pull_i & ~is_empty;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        join_d   = join_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        // Clears first so a same-cycle set event below overrides them.
        if (clr_ovf_i) ovf_d = 1'b0;
        if (clr_unf_i) unf_d = 1'b0;

        if (join_chg) begin
            join_d   = join_i;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i && is_full) ovf_d = 1'b1;
            if (pull_i && is_empty) unf_d = 1'b1;
            if (do_push) wr_ptr_d = advance(wr_ptr_q, last_idx);
            if (do_pull) rd_ptr_d = advance(rd_ptr_q, last_idx);
            unique case ({do_push, do_pull})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            join_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            join_q   <= join_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Data storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (!reset_i && do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o      = mem_q[rd_ptr_q];
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign level_o     = count_q;
    assign at_thresh_o = (count_q >= thresh_i);
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_pio_fifo_join.sv
// Bench for pio_fifo_join: three instances (32x4, 8x2, 32x16) share the control inputs.
// A queue-based reference model tracks each instance every cycle. A vector table and a
// join-mode fill/drain sequence add fixed expected values for the 32x4 instance.

module tb_pio_fifo_join;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, join_s, flush, push, pull, clr_ovf, clr_unf;
    logic [31:0] din;
    logic [3:0]  thr0;
    logic [2:0]  thr1;
    logic [5:0]  thr2;

    logic [31:0] dout0, dout2;
    logic [7:0]  dout1;
    logic [3:0]  lvl0;
    logic [2:0]  lvl1;
    logic [5:0]  lvl2;
    logic [NI-1:0] emp, ful, ath, ovf, unf;

    pio_fifo_join #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk_i(clk), .reset_i(reset), .join_i(join_s), .flush_i(flush), .push_i(push),
        .din_i(din), .pull_i(pull), .dout_o(dout0), .empty_o(emp[0]), .full_o(ful[0]),
        .level_o(lvl0), .thresh_i(thr0), .at_thresh_o(ath[0]), .overflow_o(ovf[0]),
        .underflow_o(unf[0]), .clr_ovf_i(clr_ovf), .clr_unf_i(clr_unf)
    );

    pio_fifo_join #(.WIDTH(8), .DEPTH(2)) u_w8d2 (
        .clk_i(clk), .reset_i(reset), .join_i(join_s), .flush_i(flush), .push_i(push),
        .din_i(din[7:0]), .pull_i(pull), .dout_o(dout1), .empty_o(emp[1]), .full_o(ful[1]),
        .level_o(lvl1), .thresh_i(thr1), .at_thresh_o(ath[1]), .overflow_o(ovf[1]),
        .underflow_o(unf[1]), .clr_ovf_i(clr_ovf), .clr_unf_i(clr_unf)
    );

    pio_fifo_join #(.WIDTH(32), .DEPTH(16)) u_d16 (
        .clk_i(clk), .reset_i(reset), .join_i(join_s), .flush_i(flush), .push_i(push),
        .din_i(din), .pull_i(pull), .dout_o(dout2), .empty_o(emp[2]), .full_o(ful[2]),
        .level_o(lvl2), .thresh_i(thr2), .at_thresh_o(ath[2]), .overflow_o(ovf[2]),
        .underflow_o(unf[2]), .clr_ovf_i(clr_ovf), .clr_unf_i(clr_unf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned mdepth [NI] = '{4, 2, 16};
    logic [31:0] mmask  [NI] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
    logic [31:0] mq [NI][$];
    bit          mjoin = 1'b0;
    bit          movf [NI];
    bit          munf [NI];

    function automatic int unsigned mcap(input int k);
        return mjoin ? 2 * mdepth[k] : mdepth[k];
    endfunction

    function automatic int unsigned thr_of(input int k);
        case (k)
            0:       return 32'(thr0);
            1:       return 32'(thr1);
            default: return 32'(thr2);
        endcase
    endfunction

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            bit was_full, was_empty;
            was_full  = (mq[k].size() == mcap(k));
            was_empty = (mq[k].size() == 0);
            if (reset) begin
                mq[k].delete();
                movf[k] = 1'b0;
                munf[k] = 1'b0;
            end else begin
                if (clr_ovf) movf[k] = 1'b0;
                if (clr_unf) munf[k] = 1'b0;
                if (join_s != mjoin || flush) begin
                    mq[k].delete();
                end else begin
                    if (push && was_full) movf[k] = 1'b1;
                    if (pull && was_empty) munf[k] = 1'b1;
                    if (pull && !was_empty) void'(mq[k].pop_front());
                    if (push && !was_full) mq[k].push_back(din & mmask[k]);
                end
            end
        end
        mjoin = reset ? 1'b0 : join_s;
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            logic [31:0] a_lvl, a_dout;
            int unsigned n;
            case (k)
                0:       begin a_lvl = 32'(lvl0); a_dout = dout0;        end
                1:       begin a_lvl = 32'(lvl1); a_dout = 32'(dout1);   end
                default: begin a_lvl = 32'(lvl2); a_dout = dout2;        end
            endcase
            n = mq[k].size();
            chk("level", k, a_lvl, n);
            chk("empty", k, 32'(emp[k]), 32'(n == 0));
            chk("full", k, 32'(ful[k]), 32'(n == mcap(k)));
            chk("at_thresh", k, 32'(ath[k]), 32'(n >= thr_of(k)));
            chk("overflow", k, 32'(ovf[k]), 32'(movf[k]));
            chk("underflow", k, 32'(unf[k]), 32'(munf[k]));
            if (n != 0) chk("dout", k, a_dout, mq[k][0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; push = 1'b0; pull = 1'b0;
        clr_ovf = 1'b0; clr_unf = 1'b0; din = '0;
    endtask

    task automatic set_thr(input int t);
        thr0 = 4'(t); thr1 = 3'(t); thr2 = 6'(t);
    endtask

    // ---------------- vector table (expectations for the 32x4 instance) ----------------
    typedef struct {
        bit          rst, jn, fl, ps, pl;
        logic [31:0] d;
        int          thr;
        bit          co, cu;
        bit          e_empty, e_full;
        int          e_lvl;
        bit          e_ovf, e_unf, e_ath, chkd;
        logic [31:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit rst, jn, fl, ps, pl, input logic [31:0] d, input int thr,
                        input bit co, cu, ee, ef, input int el, input bit eo, eu, ea, cd,
                        input logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.jn = jn; v.fl = fl; v.ps = ps; v.pl = pl; v.d = d; v.thr = thr;
        v.co = co; v.cu = cu; v.e_empty = ee; v.e_full = ef; v.e_lvl = el; v.e_ovf = eo;
        v.e_unf = eu; v.e_ath = ea; v.chkd = cd; v.e_dout = ed;
        tbl.push_back(v);
    endtask

    initial begin
        idle_inputs();
        join_s = 1'b0;
        set_thr(0);

        //   rst jn fl ps pl din    thr co cu | emp ful lvl ovf unf ath chkd dout
        addv(1, 0, 0, 0, 0, 0,      0,  0, 0,   1,  0,  0,  0,  0,  1,  0,   0);
        addv(0, 0, 0, 1, 0, 'hA0,   5,  0, 0,   0,  0,  1,  0,  0,  0,  1,   'hA0);
        addv(0, 0, 0, 1, 0, 'hA1,   5,  0, 0,   0,  0,  2,  0,  0,  0,  1,   'hA0);
        addv(0, 0, 0, 1, 0, 'hA2,   5,  0, 0,   0,  0,  3,  0,  0,  0,  1,   'hA0);
        addv(0, 0, 0, 1, 0, 'hA3,   5,  0, 0,   0,  1,  4,  0,  0,  0,  1,   'hA0);
        addv(0, 0, 0, 1, 0, 'hA4,   5,  0, 0,   0,  1,  4,  1,  0,  0,  1,   'hA0);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   0,  0,  3,  1,  0,  0,  1,   'hA1);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   0,  0,  2,  1,  0,  0,  1,   'hA2);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   0,  0,  1,  1,  0,  0,  1,   'hA3);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   1,  0,  0,  1,  0,  0,  0,   0);
        addv(0, 0, 0, 1, 0, 'hB0,   5,  0, 0,   0,  0,  1,  1,  0,  0,  1,   'hB0);
        addv(0, 0, 0, 1, 0, 'hB1,   5,  0, 0,   0,  0,  2,  1,  0,  0,  1,   'hB0);
        addv(0, 0, 0, 1, 1, 'hB2,   5,  0, 0,   0,  0,  2,  1,  0,  0,  1,   'hB1);
        addv(0, 0, 0, 1, 0, 'hB3,   5,  1, 0,   0,  0,  3,  0,  0,  0,  1,   'hB1);
        addv(0, 0, 0, 1, 0, 'hB4,   5,  0, 0,   0,  1,  4,  0,  0,  0,  1,   'hB1);
        addv(0, 0, 0, 1, 1, 'hB5,   5,  0, 0,   0,  0,  3,  1,  0,  0,  1,   'hB2);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   0,  0,  2,  1,  0,  0,  1,   'hB3);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   0,  0,  1,  1,  0,  0,  1,   'hB4);
        addv(0, 0, 0, 0, 1, 0,      5,  0, 0,   1,  0,  0,  1,  0,  0,  0,   0);
        addv(0, 0, 0, 1, 1, 'hC0,   5,  0, 0,   0,  0,  1,  1,  1,  0,  1,   'hC0);
        addv(0, 0, 0, 1, 0, 'hC1,   5,  0, 0,   0,  0,  2,  1,  1,  0,  1,   'hC0);
        addv(0, 0, 0, 1, 0, 'hC2,   5,  0, 0,   0,  0,  3,  1,  1,  0,  1,   'hC0);
        addv(0, 1, 0, 1, 0, 'hC3,   5,  0, 0,   1,  0,  0,  1,  1,  0,  0,   0);
        addv(0, 1, 0, 1, 0, 'hD0,   5,  0, 0,   0,  0,  1,  1,  1,  0,  1,   'hD0);
        addv(0, 1, 1, 1, 0, 'hD1,   5,  0, 0,   1,  0,  0,  1,  1,  0,  0,   0);
        addv(0, 1, 0, 0, 0, 0,      5,  1, 1,   1,  0,  0,  0,  0,  0,  0,   0);
        addv(0, 0, 0, 0, 0, 0,      5,  0, 0,   1,  0,  0,  0,  0,  0,  0,   0);
        addv(0, 0, 0, 1, 0, 'hE0,   5,  0, 0,   0,  0,  1,  0,  0,  0,  1,   'hE0);
        addv(0, 0, 0, 1, 0, 'hE1,   5,  0, 0,   0,  0,  2,  0,  0,  0,  1,   'hE0);
        addv(0, 0, 0, 1, 0, 'hE2,   5,  0, 0,   0,  0,  3,  0,  0,  0,  1,   'hE0);
        addv(0, 0, 0, 1, 0, 'hE3,   5,  0, 0,   0,  1,  4,  0,  0,  0,  1,   'hE0);
        addv(0, 0, 0, 1, 0, 'hE4,   5,  1, 0,   0,  1,  4,  1,  0,  0,  1,   'hE0);
        addv(0, 0, 1, 0, 0, 0,      3,  0, 0,   1,  0,  0,  1,  0,  0,  0,   0);
        addv(0, 0, 0, 1, 0, 'hF0,   3,  0, 0,   0,  0,  1,  1,  0,  0,  1,   'hF0);
        addv(0, 0, 0, 1, 0, 'hF1,   3,  0, 0,   0,  0,  2,  1,  0,  0,  1,   'hF0);
        addv(0, 0, 0, 1, 0, 'hF2,   3,  0, 0,   0,  0,  3,  1,  0,  1,  1,   'hF0);
        addv(0, 0, 0, 0, 1, 0,      3,  0, 0,   0,  0,  2,  1,  0,  0,  1,   'hF1);
        addv(1, 0, 0, 0, 0, 0,      3,  0, 0,   1,  0,  0,  0,  0,  0,  0,   0);
        addv(0, 0, 0, 1, 0, 'h55,   3,  0, 0,   0,  0,  1,  0,  0,  0,  1,   'h55);
        addv(0, 0, 0, 0, 0, 0,      1,  0, 0,   0,  0,  1,  0,  0,  1,  1,   'h55);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; join_s = tbl[i].jn; flush = tbl[i].fl;
            push = tbl[i].ps; pull = tbl[i].pl; din = tbl[i].d;
            clr_ovf = tbl[i].co; clr_unf = tbl[i].cu;
            set_thr(tbl[i].thr);
            step();
            chk("tbl_empty", i, 32'(emp[0]), 32'(tbl[i].e_empty));
            chk("tbl_full", i, 32'(ful[0]), 32'(tbl[i].e_full));
            chk("tbl_level", i, 32'(lvl0), tbl[i].e_lvl);
            chk("tbl_overflow", i, 32'(ovf[0]), 32'(tbl[i].e_ovf));
            chk("tbl_underflow", i, 32'(unf[0]), 32'(tbl[i].e_unf));
            chk("tbl_at_thresh", i, 32'(ath[0]), 32'(tbl[i].e_ath));
            if (tbl[i].chkd) chk("tbl_dout", i, dout0, tbl[i].e_dout);
        end

        // Joined mode: three fill/drain rounds of 8 words exercise pointer wrap.
        idle_inputs();
        set_thr(0);
        join_s = 1'b1;
        step();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                push = 1'b1; din = 32'(r * 16 + i);
                step();
                chk("join_level", r, 32'(lvl0), 32'(i + 1));
                chk("join_full", r, 32'(ful[0]), 32'(i == 7));
            end
            push = 1'b0;
            for (int i = 0; i < 8; i++) begin
                chk("join_head", r, dout0, 32'(r * 16 + i));
                pull = 1'b1;
                step();
            end
            pull = 1'b0;
            chk("join_drained", r, 32'(emp[0]), 32'd1);
        end

        // Randomised traffic against the model on all three instances.
        for (int n = 0; n < 4000; n++) begin
            int pb, lb;
            bit quiet;
            pb = ((n / 500) % 2 == 0) ? 70 : 35;
            lb = ((n / 500) % 2 == 0) ? 35 : 70;
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 79) == 0) join_s = ~join_s;
            flush = ($urandom_range(0, 59) == 0);
            push  = ($urandom_range(0, 99) < pb);
            pull  = ($urandom_range(0, 99) < lb);
            din   = $urandom;
            quiet = !flush && (join_s == mjoin);
            clr_ovf = quiet && ($urandom_range(0, 11) == 0);
            clr_unf = quiet && ($urandom_range(0, 11) == 0);
            thr0 = 4'($urandom_range(0, 9));
            thr1 = 3'($urandom_range(0, 5));
            thr2 = 6'($urandom_range(0, 33));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
